// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: default geometry, pointer types and Gray/binary helpers.
// Used by both the write-side full controller and the read-side empty calculator.
package async_fifo_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 4;
  localparam int unsigned MAX_ADDRESS_WIDTH = 12;

  typedef logic [DEF_ADDRESS_WIDTH:0] ptr_t;
  // Widest legal pointer; helpers operate on zero-extended values of this width.
  typedef logic [MAX_ADDRESS_WIDTH:0] ptr_max_t;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = '0;
    b[MAX_ADDRESS_WIDTH] = g[MAX_ADDRESS_WIDTH];
    for (int unsigned i = MAX_ADDRESS_WIDTH; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/wr_full_ctrl_gray2bin_conv.sv
// Parameterized combinational Gray-to-binary converter.
module gray2bin_conv #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wr_full_ctrl.sv
// Async FIFO write-domain pointer, FULL/AFULL and fill-level controller.
// Optional sticky OVERFLOW detection is enabled with `define WR_OVF_DET_EN.
module wr_full_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned AFULL_SLOTS   = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     W_inc,
  input  logic [ADDRESS_WIDTH:0]   Wq2_Rptr,
  output logic [ADDRESS_WIDTH-1:0] W_addr,
  output logic [ADDRESS_WIDTH:0]   W_ptr,
  output logic                     FULL,
  output logic                     AFULL,
  output logic [ADDRESS_WIDTH:0]   W_level
`ifdef WR_OVF_DET_EN
  ,
  input  logic                     OVF_clr,
  output logic                     OVERFLOW
`endif
);

  localparam int unsigned PW    = ADDRESS_WIDTH + 1;
  localparam int unsigned DEPTH = fifo_depth(ADDRESS_WIDTH);
  localparam logic [PW-1:0] AFULL_THR = PW'(DEPTH - AFULL_SLOTS);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_n;
  logic [PW-1:0] wgray_n;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_n;
  logic [PW-1:0] full_cmp;
  logic          inc_ok;
  logic          full_n;
  logic          afull_n;

  gray2bin_conv #(
    .WIDTH (PW)
  ) u_rptr_g2b (
    .gray (Wq2_Rptr),
    .bin  (rbin)
  );

  // Flags are computed from the next-state pointer so they land on the same edge as the write.
  always_comb begin
    inc_ok   = W_inc & ~FULL;
    wbin_n   = wbin + {{(PW-1){1'b0}}, inc_ok};
    wgray_n  = PW'(bin2gray(ptr_max_t'(wbin_n)));
    full_cmp = {~Wq2_Rptr[ADDRESS_WIDTH:ADDRESS_WIDTH-1], Wq2_Rptr[ADDRESS_WIDTH-2:0]};
    full_n   = (wgray_n == full_cmp);
    level_n  = wbin_n - rbin;
    afull_n  = (level_n >= AFULL_THR);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wbin    <= '0;
      W_ptr   <= '0;
      FULL    <= 1'b0;
      AFULL   <= 1'b0;
      W_level <= '0;
    end else begin
      wbin    <= wbin_n;
      W_ptr   <= wgray_n;
      FULL    <= full_n;
      AFULL   <= afull_n;
      W_level <= level_n;
    end
  end

  assign W_addr = wbin[ADDRESS_WIDTH-1:0];

`ifdef WR_OVF_DET_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVERFLOW <= 1'b0;
    end else if (W_inc & FULL) begin
      OVERFLOW <= 1'b1;
    end else if (OVF_clr) begin
      OVERFLOW <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_wr_full_ctrl.sv
// Self-checking bench for wr_full_ctrl (depth 16, AFULL_SLOTS 2) against an occupancy-count model.
module tb_wr_full_ctrl;

  logic       CLK;
  logic       RST;
  logic       W_inc;
  logic [4:0] Wq2_Rptr;
  logic [3:0] W_addr;
  logic [4:0] W_ptr;
  logic       FULL;
  logic       AFULL;
  logic [4:0] W_level;
`ifdef WR_OVF_DET_EN
  logic       OVF_clr;
  logic       OVERFLOW;
`endif

  int total = 0;
  int bad   = 0;

  // Model: counts of writes accepted and reads seen, as plain integers.
  int wcnt = 0;
  int rcnt = 0;
  bit mfull = 0;
  bit movf  = 0;

  wr_full_ctrl #(
    .ADDRESS_WIDTH (4),
    .AFULL_SLOTS   (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .W_inc    (W_inc),
    .Wq2_Rptr (Wq2_Rptr),
    .W_addr   (W_addr),
    .W_ptr    (W_ptr),
    .FULL     (FULL),
    .AFULL    (AFULL),
    .W_level  (W_level)
`ifdef WR_OVF_DET_EN
    ,
    .OVF_clr  (OVF_clr),
    .OVERFLOW (OVERFLOW)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [4:0] gray5(input int v);
    int b;
    b = v % 32;
    return 5'(b ^ (b / 2));
  endfunction

  function automatic logic [4:0] exp_level();
    return 5'(wcnt - rcnt);
  endfunction

  task automatic set_rd(input int r);
    rcnt = r;
    Wq2_Rptr = gray5(r);
  endtask

  task automatic model_reset();
    wcnt = 0;
    rcnt = 0;
    mfull = 0;
    movf = 0;
  endtask

  // Advance one clock, update the model with the inputs present at the edge, sample 1ns later.
  task automatic clk_step();
    bit acc;
    bit ovf_set;
    @(posedge CLK);
    acc = W_inc && !mfull;
    ovf_set = W_inc && mfull;
    if (acc) wcnt++;
    mfull = ((wcnt - rcnt) == 16);
`ifdef WR_OVF_DET_EN
    if (ovf_set) movf = 1;
    else if (OVF_clr) movf = 0;
`else
    if (ovf_set) movf = 1;
`endif
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    W_inc = 1'b0;
    set_rd(0);
`ifdef WR_OVF_DET_EN
    OVF_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    total++;
    if ({W_addr, W_ptr, FULL, AFULL, W_level} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%0d ptr=%b full=%b afull=%b level=%0d, want all 0",
               W_addr, W_ptr, FULL, AFULL, W_level);
    end
`ifdef WR_OVF_DET_EN
    total++;
    if (OVERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL reset_overflow: got %b want 0", OVERFLOW);
    end
`endif
    clk_step();
    total++;
    if (W_level !== 5'd0 || FULL !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_edge: got level=%0d full=%b want 0/0", W_level, FULL);
    end
  endtask

  task automatic test_fill();
    set_rd(0);
    W_inc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      clk_step();
      total++;
      if (W_level !== exp_level() || AFULL !== (exp_level() >= 14) || FULL !== mfull) begin
        bad++;
        $display("FAIL fill_w%0d: got level=%0d afull=%b full=%b want level=%0d afull=%b full=%b",
                 i, W_level, AFULL, FULL, exp_level(), (exp_level() >= 14), mfull);
      end
      if (i == 14) begin
        total++;
        if (AFULL !== 1'b1 || W_level !== 5'd14) begin
          bad++;
          $display("FAIL fill_afull14: got afull=%b level=%0d want 1/14", AFULL, W_level);
        end
      end
    end
    W_inc = 1'b0;
    total++;
    if (FULL !== 1'b1 || W_level !== 5'd16 || W_ptr !== 5'b11000 || W_addr !== 4'd0) begin
      bad++;
      $display("FAIL fill_end: got full=%b level=%0d ptr=%b addr=%0d want 1/16/11000/0",
               FULL, W_level, W_ptr, W_addr);
    end
  endtask

  task automatic test_overflow();
    W_inc = 1'b1;
    clk_step();
    W_inc = 1'b0;
    total++;
    if (W_ptr !== 5'b11000 || W_addr !== 4'd0 || W_level !== 5'd16 || FULL !== 1'b1) begin
      bad++;
      $display("FAIL ovf_dropped: got ptr=%b addr=%0d level=%0d full=%b want 11000/0/16/1",
               W_ptr, W_addr, W_level, FULL);
    end
`ifdef WR_OVF_DET_EN
    repeat (2) clk_step();
    total++;
    if (OVERFLOW !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got %b want 1", OVERFLOW);
    end
    OVF_clr = 1'b1;
    W_inc = 1'b1;
    clk_step();
    W_inc = 1'b0;
    total++;
    if (OVERFLOW !== movf || OVERFLOW !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set_wins: got %b want 1", OVERFLOW);
    end
    clk_step();
    OVF_clr = 1'b0;
    total++;
    if (OVERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got %b want 0", OVERFLOW);
    end
`endif
  endtask

  task automatic test_drain_release();
    set_rd(16);
    clk_step();
    total++;
    if (FULL !== 1'b0 || AFULL !== 1'b0 || W_level !== 5'd0) begin
      bad++;
      $display("FAIL drain_release: got full=%b afull=%b level=%0d want 0/0/0", FULL, AFULL, W_level);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    for (int i = 0; i < 40; i++) begin
      prev = W_ptr;
      W_inc = 1'b1;
      clk_step();
      W_inc = 1'b0;
      total++;
      if (W_addr !== 4'(wcnt % 16) || W_ptr !== gray5(wcnt) || FULL !== 1'b0 ||
          $countones(prev ^ W_ptr) != 1) begin
        bad++;
        $display("FAIL wrap_w%0d: got addr=%0d ptr=%b full=%b prev=%b want addr=%0d ptr=%b full=0",
                 i, W_addr, W_ptr, FULL, prev, wcnt % 16, gray5(wcnt));
      end
      set_rd(wcnt);
      clk_step();
    end
    total++;
    if (W_level !== 5'd0) begin
      bad++;
      $display("FAIL wrap_level: got %0d want 0", W_level);
    end
  endtask

  task automatic test_random();
    logic [4:0] prev;
    for (int i = 0; i < 400; i++) begin
      W_inc = ($urandom % 4) != 0;
      if (($urandom % 3) == 0 && rcnt < wcnt) set_rd(rcnt + 1);
`ifdef WR_OVF_DET_EN
      OVF_clr = ($urandom % 8) == 0;
`endif
      prev = W_ptr;
      clk_step();
      total++;
      if (W_addr !== 4'(wcnt % 16) || W_ptr !== gray5(wcnt) || FULL !== mfull ||
          W_level !== exp_level() || AFULL !== (exp_level() >= 14) ||
          $countones(prev ^ W_ptr) > 1) begin
        bad++;
        $display("FAIL rand_c%0d: got addr=%0d ptr=%b full=%b afull=%b level=%0d want addr=%0d ptr=%b full=%b afull=%b level=%0d",
                 i, W_addr, W_ptr, FULL, AFULL, W_level,
                 wcnt % 16, gray5(wcnt), mfull, (exp_level() >= 14), exp_level());
      end
`ifdef WR_OVF_DET_EN
      total++;
      if (OVERFLOW !== movf) begin
        bad++;
        $display("FAIL rand_ovf_c%0d: got %b want %b", i, OVERFLOW, movf);
      end
`endif
    end
    W_inc = 1'b0;
`ifdef WR_OVF_DET_EN
    OVF_clr = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    set_rd(wcnt);
    clk_step();
    W_inc = 1'b1;
    repeat (9) clk_step();
    W_inc = 1'b0;
    total++;
    if (W_level !== 5'd9) begin
      bad++;
      $display("FAIL mid_setup_level: got %0d want 9", W_level);
    end
    #2;
    RST = 1'b0;
    model_reset();
    set_rd(0);
    #1;
    total++;
    if ({W_addr, W_ptr, FULL, AFULL, W_level} !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset_async: got addr=%0d ptr=%b full=%b afull=%b level=%0d want all 0",
               W_addr, W_ptr, FULL, AFULL, W_level);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_release();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wr_full_ctrl.md
# wr_full_ctrl

Write-domain pointer and full-flag controller for the async FIFO; it is the write-side counterpart of the read-domain empty calculator. It keeps the binary and Gray write pointers and supplies the RAM write address. It compares the next Gray write pointer against the read pointer (already synchronized into CLK) to register FULL. It also registers a fill level and an almost-full flag, so upstream producers can throttle before FULL.

## Interface
- ADDRESS_WIDTH, 4: RAM address bits; FIFO depth = 2^ADDRESS_WIDTH; legal range 2..12.
- AFULL_SLOTS, 2: AFULL asserts when free slots ≤ AFULL_SLOTS; legal range 1..depth-1.

- CLK  in  1  write-domain clock.
- RST  in  1  reset, asynchronous, active-low.
- W_inc  in  1  write request for this cycle.
- Wq2_Rptr  in  ADDRESS_WIDTH+1  Gray read pointer, 2-FF synchronized into CLK outside this block.
- W_addr  out  ADDRESS_WIDTH  RAM write address (binary pointer LSBs).
- W_ptr  out  ADDRESS_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- FULL  out  1  FIFO full; writes are blocked.
- AFULL  out  1  almost full.
- W_level  out  ADDRESS_WIDTH+1  occupancy seen from the write domain, 0..depth.
- OVF_clr  in  1  clears OVERFLOW. Present only with WR_OVF_DET_EN.
- OVERFLOW  out  1  sticky flag: a write was attempted while full. Present only with WR_OVF_DET_EN.

## Operation
- Binary pointer next value: wbin_n = wbin + (W_inc & ~FULL), modulo 2^(ADDRESS_WIDTH+1).
- Gray conversion: wgray_n = wbin_n ^ (wbin_n >> 1).
- Full condition: full_n = (wgray_n == {~Wq2_Rptr[AW:AW-1], Wq2_Rptr[AW-2:0]}), where AW = ADDRESS_WIDTH.
- Read pointer in binary: rbin = Gray-to-binary of Wq2_Rptr, computed by an XOR prefix from the MSB.
- Level: level_n = wbin_n − rbin, modulo 2^(AW+1). This is always ≤ depth for a legal Wq2_Rptr.
- Almost full: afull_n = (level_n ≥ depth − AFULL_SLOTS).
- Registered on every CLK edge: wbin ← wbin_n, W_ptr ← wgray_n, FULL ← full_n, W_level ← level_n, AFULL ← afull_n.
- W_addr = wbin[AW-1:0]. It is combinational from the register, with no extra logic.
- W_inc while FULL=1: the write is dropped. wbin, W_addr and W_ptr stay unchanged.
- Wrap-around: the pointer wraps from 2^(AW+1)−1 to 0 with no special case. The Gray MSB pair inversion handles lap detection.
- Read progress reaches this block only through the external synchronizer. FULL and AFULL therefore release late (pessimistic) and never early.
- Reset values: wbin=0, W_ptr=0, W_addr=0, FULL=0, AFULL=0, W_level=0, OVERFLOW=0.
- Reset asserted mid-operation: all registers clear immediately, asynchronously. The read side must be reset in the same window.

## Timing
- All flags and W_level are registered. A write accepted at edge N is reflected in FULL, AFULL and W_level right after edge N. The flag computation uses the next-state pointer, so there is no additional cycle of latency.
- A change on Wq2_Rptr is reflected after the next CLK edge.
- W_ptr changes at most one bit per edge, which is required for safe CDC.
- If W_inc and a Wq2_Rptr advance land in the same cycle, both apply in that cycle. The level stays unchanged and FULL is evaluated against the new read pointer.

## Configuration
- WR_OVF_DET_EN defined:
  - Adds the OVF_clr and OVERFLOW ports.
  - OVERFLOW sets on any cycle with W_inc & FULL.
  - OVF_clr clears OVERFLOW. If clear and set happen in the same cycle, set wins.
  - OVERFLOW stays held until cleared or reset.
- WR_OVF_DET_EN undefined: both ports and the register are absent. Dropped writes are silent.

## Structure
- Shared package async_fifo_pkg holds:
  - the default ADDRESS_WIDTH;
  - a depth constant function;
  - the pointer-width typedef (ADDRESS_WIDTH+1);
  - bin2gray and gray2bin functions, shared with the read-side empty calculator.
- One sub-module, gray2bin_conv: a parameterized combinational Gray-to-binary converter used on Wq2_Rptr.
- Everything else is flat in wr_full_ctrl.

## Test plan
All scenarios use depth 16, ADDRESS_WIDTH=4, AFULL_SLOTS=2.
- **Reset:** hold RST=0, then release → all outputs are 0 and W_addr=0.
- **Fill:** Wq2_Rptr=0, W_inc=1 for 16 cycles → AFULL=1 after write 14 (W_level=14); FULL=1 after write 16; W_level=16; W_ptr=5'b11000.
- **Overflow:**
  - Start full; pulse W_inc once → W_ptr, W_addr and W_level are unchanged. With the macro, OVERFLOW=1 stays set until an OVF_clr pulse.
  - Pulse OVF_clr and W_inc in the same cycle → OVERFLOW stays 1 (set wins).
- **Drain and release:** start full; drive Wq2_Rptr=5'b11000 (read pointer 16) → after one edge FULL=0, AFULL=0, W_level=0.
- **Wrap:** run 40 single writes, each followed by a matching read-pointer update → W_addr cycles 0..15 and wraps; FULL is never set; W_ptr changes one bit per write.
- **Reset mid-operation:** assert RST low when W_level=9 → all outputs clear asynchronously, before the next CLK edge.
